// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//   Bundles the two writeback request channels, the RegFile write port and
//   the pending-write mask that belong to rf_write_arbiter.
//   slave  : arbiter side. Takes the requests in and drives ready, the
//            RegFile port and busy_mask out.
//   master : requester/RegFile side. The mirror of slave.
//   Channel k (k = 0,1): reqk_valid/reqk_dst/reqk_data in, reqk_ready back.
//   RegFile: rf_dst, rf_data, rf_wrt_en.
//   busy_mask: one bit per register, set while a held write is pending.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NREGS = 1 << ADDR_W;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_dst;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_dst;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic [ADDR_W-1:0] rf_dst;
  logic [DATA_W-1:0] rf_data;
  logic              rf_wrt_en;
  logic [NREGS-1:0]  busy_mask;

  modport slave (
    input  req0_valid, req0_dst, req0_data,
    input  req1_valid, req1_dst, req1_data,
    output req0_ready, req1_ready,
    output rf_dst, rf_data, rf_wrt_en, busy_mask
  );

  modport master (
    output req0_valid, req0_dst, req0_data,
    output req1_valid, req1_dst, req1_data,
    input  req0_ready, req1_ready,
    input  rf_dst, rf_data, rf_wrt_en, busy_mask
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the single RegFile write port between two writeback requesters.
//   Each requester owns a one-entry holding slot. The oldest held write is
//   granted first. Two writes that entered on the same edge are ordered by a
//   round-robin pointer. The granted slot drives the RegFile port directly
//   and clears on the edge that commits it.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous reset, active low (0 = reset)
//     bus  : rf_write_arbiter_if.slave. Two request channels, the RegFile
//            write port, and the per-register pending-write mask.
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  rf_write_arbiter_if.slave   bus
);
  localparam int NREGS = 1 << ADDR_W;

  // Slot state
  logic [1:0]        full_q, full_d;
  logic [ADDR_W-1:0] dst_q  [2];
  logic [ADDR_W-1:0] dst_d  [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];

  // Ordering state
  logic age_q, age_d;       // 1 = slot1 is older when both slots are full
  logic rr_q, rr_d;         // slot that wins the next tie
  logic tie_q, tie_d;       // both slots were filled on the same edge

  logic       any_full;
  logic       gnt_sel;      // index of the granted slot (valid when any_full)
  logic [1:0] gnt;
  logic [1:0] ready;
  logic [1:0] acc;

  // Grant selection and handshake
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    any_full = |full_q;
    gnt_sel  = full_q[1];
    if (&full_q) gnt_sel = tie_q ? rr_q : age_q;
    gnt      = any_full ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
    // A slot can refill on the same edge that drains it.
    ready    = ~full_q | gnt;
    acc      = {bus.req1_valid, bus.req0_valid} & ready;
  end

  // Next-state logic
  always_comb begin
    full_d    = (full_q & ~gnt) | acc;
    dst_d[0]  = dst_q[0];
    dst_d[1]  = dst_q[1];
    data_d[0] = data_q[0];
    data_d[1] = data_q[1];
    if (acc[0]) begin
      dst_d[0]  = bus.req0_dst;
      data_d[0] = bus.req0_data;
    end
    if (acc[1]) begin
      dst_d[1]  = bus.req1_dst;
      data_d[1] = bus.req1_data;
    end

    // The slot filled later becomes the younger one. On a simultaneous fill,
    // age is left alone because tie_q hands the decision to rr_q.
    age_d = age_q;
    case (acc)
      2'b01:   age_d = 1'b1;
      2'b10:   age_d = 1'b0;
      default: age_d = age_q;
    endcase
    tie_d = &acc;

    // A tie grant always happens when both slots are full with tie_q set.
    rr_d = rr_q ^ (&full_q & tie_q);
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
      age_q  <= 1'b0;
      rr_q   <= 1'b0;
      tie_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      age_q  <= age_d;
      rr_q   <= rr_d;
      tie_q  <= tie_d;
    end
  end

  // NOTE: the payload is deliberately left out of the reset. It is only
  // observed through full_q, and clearing full_q discards the held writes.
  always_ff @(posedge clk) begin
    dst_q[0]  <= dst_d[0];
    dst_q[1]  <= dst_d[1];
    data_q[0] <= data_d[0];
    data_q[1] <= data_d[1];
  end

  // Outputs. All of them come from state, so an asynchronous reset idles
  // them at once.
  always_comb begin
    bus.req0_ready = ready[0];
    bus.req1_ready = ready[1];
    bus.rf_wrt_en  = any_full;
    bus.rf_dst     = any_full ? dst_q[gnt_sel]  : '0;
    bus.rf_data    = any_full ? data_q[gnt_sel] : '0;
    bus.busy_mask  = '0;
    for (int i = 0; i < NREGS; i++) begin
      bus.busy_mask[i] = (full_q[0] && dst_q[0] == ADDR_W'(i)) ||
                         (full_q[1] && dst_q[1] == ADDR_W'(i));
    end
  end
endmodule
